// File: rtl/simple_pkg.sv
// Shared types and helpers for the simple_pipe multiply-add datapath and its
// reusable accumulate/narrow stage.
package simple_pkg;
  localparam int LATENCY = 3;
  // Widest intermediate: a 65-bit accumulator sum plus sign-extension headroom.
  localparam int MAX_W   = 68;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

  typedef struct packed {
    logic signed [MAX_W-1:0] val;
    logic                    ovf;
  } narrow_t;

  function automatic int full_w(input int w);
    return 2*w + 1;
  endfunction

  // Narrow val to width bits: clamp when sat=1, two's-complement wrap otherwise.
  function automatic narrow_t sat_narrow(input logic signed [MAX_W-1:0] val,
                                         input int width, input logic sat);
    logic signed [MAX_W-1:0] maxv, minv, tmp;
    narrow_t res;
    maxv    = (MAX_W'(1) <<< (width-1)) - MAX_W'(1);
    minv    = ~maxv;
    res.ovf = (val > maxv) || (val < minv);
    tmp     = val <<< (MAX_W - width);
    tmp     = tmp >>> (MAX_W - width);
    if (!res.ovf)  res.val = val;
    else if (sat)  res.val = val[MAX_W-1] ? minv : maxv;
    else           res.val = tmp;
    return res;
  endfunction
endpackage

// File: rtl/simple_pipe_if.sv
// Sample/result bus of simple_pipe; master is the sample source, slave the pipe.
interface simple_pipe_if #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 31
);
  logic                    ce;
  logic                    in_valid;
  logic                    sub;
  logic                    acc;
  logic signed [IN_W-1:0]  A;
  logic signed [IN_W-1:0]  B;
  logic signed [IN_W-1:0]  C;
  logic                    clr_ovf;
  logic                    out_valid;
  logic signed [OUT_W-1:0] Y;
  logic                    ovf;

  modport master (output ce, in_valid, sub, acc, A, B, C, clr_ovf,
                  input  out_valid, Y, ovf);
  modport slave  (input  ce, in_valid, sub, acc, A, B, C, clr_ovf,
                  output out_valid, Y, ovf);
endinterface

// File: rtl/simple_satacc.sv
// Final stage: optional accumulate onto Y, narrow to OUT_W (saturate or wrap)
// and keep a sticky overflow flag.
module simple_satacc
  import simple_pkg::*;
#(
  parameter int P_W   = 31,
  parameter int OUT_W = 31,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    vin,
  input  logic                    acc,
  input  logic signed [P_W-1:0]   p,
  input  logic                    clr_ovf,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);
  if (OUT_W > P_W || P_W + 1 > MAX_W - 1) begin : g_bad_w
    $error("simple_satacc: unsupported P_W=%0d / OUT_W=%0d", P_W, OUT_W);
  end

  logic signed [P_W:0]     y_x, p_x, r;
  logic signed [MAX_W-1:0] r_x;
  narrow_t                 nr;
  logic                    unused_hi;

  // One extra bit keeps Y + P exact before narrowing.
  assign y_x       = acc ? {{(P_W+1-OUT_W){y[OUT_W-1]}}, y} : '0;
  assign p_x       = {p[P_W-1], p};
  assign r         = y_x + p_x;
  assign r_x       = {{(MAX_W-P_W-1){r[P_W]}}, r};
  assign nr        = sat_narrow(r_x, OUT_W, SAT != 0);
  assign unused_hi = ^nr.val[MAX_W-1:OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= '0;
      ovf <= 1'b0;
    end else begin
      if (en && vin) y <= nr.val[OUT_W-1:0];
      // A new overflow beats a simultaneous clear; clear ignores the enable.
      if (en && vin && nr.ovf) ovf <= 1'b1;
      else if (clr_ovf)        ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/simple_pipe.sv
// Three-stage signed Y = C * (A +/- B) with optional accumulation, stalled by ce.
module simple_pipe
  import simple_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int OUT_W = 31,
  parameter int SAT   = 1
) (
  input logic          clk,
  input logic          rst,
  simple_pipe_if.slave bus
);
  localparam int FW = full_w(IN_W);

  if (IN_W < 2 || IN_W > 32) begin : g_bad_in
    $error("simple_pipe: IN_W=%0d outside 2..32", IN_W);
  end
  if (OUT_W < IN_W + 1 || OUT_W > FW) begin : g_bad_out
    $error("simple_pipe: OUT_W=%0d outside %0d..%0d", OUT_W, IN_W + 1, FW);
  end

  typedef struct packed {
    logic signed [IN_W:0]   d;
    logic signed [IN_W-1:0] c;
    logic                   acc;
  } s1_t;

  typedef struct packed {
    logic signed [FW-1:0] p;
    logic                 acc;
  } s2_t;

  logic [LATENCY:1]     vld_pipe;
  s1_t                  s1_d, s1_q;
  s2_t                  s2_q;
  logic signed [IN_W:0] a_x, b_x;
  logic signed [FW-1:0] c_x, d_x;

  assign a_x = {bus.A[IN_W-1], bus.A};
  assign b_x = {bus.B[IN_W-1], bus.B};

  always_comb begin
    s1_d     = '0;
    s1_d.c   = bus.C;
    s1_d.acc = bus.acc;
    s1_d.d   = (op_e'(bus.sub) == OP_SUB) ? a_x - b_x : a_x + b_x;
  end

  // Operands widened to the full product width so the multiply is exact.
  assign c_x = {{(FW-IN_W){s1_q.c[IN_W-1]}}, s1_q.c};
  assign d_x = {{(FW-IN_W-1){s1_q.d[IN_W]}}, s1_q.d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (bus.ce) begin
      vld_pipe <= {vld_pipe[LATENCY-1:1], bus.in_valid};
      s1_q     <= s1_d;
      s2_q.p   <= c_x * d_x;
      s2_q.acc <= s1_q.acc;
    end
  end

  simple_satacc #(
    .P_W   (FW),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_satacc (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.ce),
    .vin     (vld_pipe[LATENCY-1]),
    .acc     (s2_q.acc),
    .p       (s2_q.p),
    .clr_ovf (bus.clr_ovf),
    .y       (bus.Y),
    .ovf     (bus.ovf)
  );

  assign bus.out_valid = vld_pipe[LATENCY];
endmodule

// File: tb/tb_simple_pipe.sv
// Scoreboard bench: three simple_pipe configurations share one stimulus stream;
// a negedge monitor pops hand-computed results as each output appears.
module tb_simple_pipe;
  localparam int IN_W = 15;

  typedef struct { int y; logic ovf; int cnt; } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic ce = 1'b1, in_valid = 1'b0, sub = 1'b0, acc = 1'b0, clr_ovf = 1'b0;
  logic signed [IN_W-1:0] A = '0, B = '0, C = '0;
  int   checks = 0, errors = 0, ecnt = 0;
  logic ce_q = 1'b0;
  exp_t q [3][$];

  always #5 clk = ~clk;

  simple_pipe_if #(.IN_W(IN_W), .OUT_W(31)) if0 ();
  simple_pipe_if #(.IN_W(IN_W), .OUT_W(16)) if1 ();
  simple_pipe_if #(.IN_W(IN_W), .OUT_W(16)) if2 ();

  assign if0.ce = ce; assign if0.in_valid = in_valid; assign if0.sub = sub; assign if0.acc = acc;
  assign if0.A = A;   assign if0.B = B; assign if0.C = C; assign if0.clr_ovf = clr_ovf;
  assign if1.ce = ce; assign if1.in_valid = in_valid; assign if1.sub = sub; assign if1.acc = acc;
  assign if1.A = A;   assign if1.B = B; assign if1.C = C; assign if1.clr_ovf = clr_ovf;
  assign if2.ce = ce; assign if2.in_valid = in_valid; assign if2.sub = sub; assign if2.acc = acc;
  assign if2.A = A;   assign if2.B = B; assign if2.C = C; assign if2.clr_ovf = clr_ovf;

  simple_pipe #(.IN_W(IN_W), .OUT_W(31), .SAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  simple_pipe #(.IN_W(IN_W), .OUT_W(16), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  simple_pipe #(.IN_W(IN_W), .OUT_W(16), .SAT(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Count of enabled edges gives the expected output slot of each sample.
  always @(posedge clk) begin
    ce_q <= ce && !rst;
    if (ce && !rst) ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic probe(input int i, output logic ov, output int y, output logic of);
    ov = 1'b0; y = 0; of = 1'b0;
    case (i)
      0: begin ov = if0.out_valid; y = int'(if0.Y); of = if0.ovf; end
      1: begin ov = if1.out_valid; y = int'(if1.Y); of = if1.ovf; end
      default: begin ov = if2.out_valid; y = int'(if2.Y); of = if2.ovf; end
    endcase
  endtask

  task automatic mon(input int i);
    logic ov, of;
    int   y;
    exp_t e;
    probe(i, ov, y, of);
    if (!ov) return;
    if (q[i].size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_out inst%0d actual y=%0d required no output", i, y);
      return;
    end
    e = q[i].pop_front();
    chk($sformatf("y inst%0d", i), y, e.y);
    chk($sformatf("ovf inst%0d", i), of, e.ovf);
    chk($sformatf("latency inst%0d", i), ecnt, e.cnt);
  endtask

  always @(negedge clk) begin
    if (!rst && ce_q)
      for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic chk_all(input string tag, input logic ov_req, input logic do_y,
                         input int y_req, input logic do_of, input logic of_req);
    logic ov, of;
    int   y;
    for (int i = 0; i < 3; i++) begin
      probe(i, ov, y, of);
      chk($sformatf("%s out_valid inst%0d", tag, i), ov, ov_req);
      if (do_y)  chk($sformatf("%s y inst%0d", tag, i), y, y_req);
      if (do_of) chk($sformatf("%s ovf inst%0d", tag, i), of, of_req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one sample for one enabled cycle; y0/o0 for 31-bit sat, y1/o1 16-bit sat, y2/o2 16-bit wrap.
  task automatic send(input int a, input int b, input int c, input logic s, input logic ac,
                      input int y0, input int y1, input int y2,
                      input logic o0, input logic o1, input logic o2);
    A = IN_W'(a); B = IN_W'(b); C = IN_W'(c); sub = s; acc = ac; in_valid = 1'b1;
    q[0].push_back('{y0, o0, ecnt + 3});
    q[1].push_back('{y1, o1, ecnt + 3});
    q[2].push_back('{y2, o2, ecnt + 3});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk_all("reset", 1'b0, 1'b1, 0, 1'b1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(100, 23, -2, 1'b0, 1'b0, -246, -246, -246, 1'b0, 1'b0, 1'b0);
    idle(4);
    send(5, 7, 3, 1'b1, 1'b0, -6, -6, -6, 1'b0, 1'b0, 1'b0);
    send(5, 7, 3, 1'b0, 1'b0, 36, 36, 36, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Positive overflow; clr_ovf lands on the same edge as the overflow result.
    send(16383, 16383, 16383, 1'b0, 1'b0, 536805378, 32767, 2, 1'b0, 1'b1, 1'b1);
    idle(1); clr_ovf = 1'b1;
    idle(1); clr_ovf = 1'b0;
    idle(2); clr_ovf = 1'b1;
    idle(1); clr_ovf = 1'b0;
    chk_all("clr_ovf", 1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    send(1, 2, 10, 1'b0, 1'b0, 30, 30, 30, 1'b0, 1'b0, 1'b0);
    send(1, 1, 10, 1'b0, 1'b1, 50, 50, 50, 1'b0, 1'b0, 1'b0);
    send(0, -4, 5, 1'b0, 1'b1, 30, 30, 30, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Negative extremes, accumulated past the 31-bit range.
    send(-16384, -16384, 16383, 1'b0, 1'b0, -536838144, -32768, -32768, 1'b0, 1'b1, 1'b1);
    send(-16384, -16384, 16383, 1'b0, 1'b1, -1073676288, -32768, 0, 1'b0, 1'b1, 1'b1);
    send(-16384, -16384, 16383, 1'b0, 1'b1, -1073741824, -32768, -32768, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Four-cycle stall with a sample offered that must be ignored; clear ovf while frozen.
    send(2, 3, 4, 1'b0, 1'b0, 20, 20, 20, 1'b1, 1'b1, 1'b1);
    send(3, 1, -5, 1'b0, 1'b0, -20, -20, -20, 1'b0, 1'b0, 1'b0);
    send(-7, 2, 6, 1'b1, 1'b0, -54, -54, -54, 1'b0, 1'b0, 1'b0);
    ce = 1'b0; A = 9; B = 9; C = 9; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk_all("stall", 1'b1, 1'b1, 20, 1'b0, 1'b0);
      if (k == 0) clr_ovf = 1'b1;
      if (k == 1) clr_ovf = 1'b0;
    end
    chk_all("stall_clr", 1'b1, 1'b0, 0, 1'b1, 1'b0);
    ce = 1'b1; in_valid = 1'b0;
    idle(4);

    // Asynchronous reset with two samples in flight.
    send(1, 1, 1, 1'b0, 1'b0, 2, 2, 2, 1'b0, 1'b0, 1'b0);
    send(2, 2, 2, 1'b0, 1'b0, 8, 8, 8, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 1'b0, 1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) q[i].delete();
    @(posedge clk); #3 rst = 1'b0;
    idle(6);
    chk_all("post_reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // acc=1 straight after reset builds on the reset value of Y.
    send(4, -1, -1, 1'b0, 1'b1, -3, -3, -3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) idle(1);
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0",
               q[0].size() + q[1].size() + q[2].size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
